// File: rtl/mac_pkg.sv
// Shared widths and signed types for the fully connected layer MAC element.
package mac_pkg;

    localparam int DEFAULT_A_W    = 22;
    localparam int DEFAULT_B_W    = 22;
    localparam int DEFAULT_ACC_W  = 48;
    localparam int DEFAULT_PROD_W = DEFAULT_A_W + DEFAULT_B_W;

    typedef logic signed [DEFAULT_A_W-1:0]    operand_a_t;
    typedef logic signed [DEFAULT_B_W-1:0]    operand_b_t;
    typedef logic signed [DEFAULT_PROD_W-1:0] product_t;
    typedef logic signed [DEFAULT_ACC_W-1:0]  acc_t;

endpackage : mac_pkg

// File: rtl/signed_mult_pipe.sv
// Two-stage registered signed multiplier: operand capture, then full-precision product.
module signed_mult_pipe
    import mac_pkg::*;
#(
    parameter int A_W = DEFAULT_A_W,
    parameter int B_W = DEFAULT_B_W,
    localparam int P_W = A_W + B_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic                  valid_o,
    output logic signed [P_W-1:0] prod_o
);

    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic signed [P_W-1:0] a_ext, b_ext, prod_d, prod_q;
    logic                  v1_q, v2_q;

    // Widening both operands first keeps the multiply self-sized at the product width.
    always_comb begin
        a_ext  = {{B_W{a_q[A_W-1]}}, a_q};
        b_ext  = {{A_W{b_q[B_W-1]}}, b_q};
        prod_d = a_ext * b_ext;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            a_q    <= a_i;
            b_q    <= b_i;
            prod_q <= prod_d;
            v1_q   <= valid_i;
            v2_q   <= v1_q;
        end
    end

    assign valid_o = v2_q;
    assign prod_o  = prod_q;

endmodule : signed_mult_pipe

// File: rtl/mac_unit.sv
// Pipelined signed MAC: registered product added combinationally to the caller's running sum.
module mac_unit
    import mac_pkg::*;
#(
    parameter int A_W   = DEFAULT_A_W,
    parameter int B_W   = DEFAULT_B_W,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [A_W-1:0]   data_in_a,
    input  logic signed [B_W-1:0]   data_in_b,
    input  logic signed [ACC_W-1:0] sum_in,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] sum_out
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    prod_valid;

    signed_mult_pipe #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .valid_i (i_valid),
        .a_i     (data_in_a),
        .b_i     (data_in_b),
        .valid_o (prod_valid),
        .prod_o  (prod)
    );

    generate
        if (ACC_W > P_W) begin : g_sext
            assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        end else begin : g_same
            assign prod_ext = prod;
        end
    endgenerate

    // Product register holds stale data on bubbles, so the add is gated by the valid bit.
    always_comb begin
        sum_out = sum_in;
        if (prod_valid) begin
            sum_out = sum_in + prod_ext;
        end
    end

    assign o_valid = prod_valid;

endmodule : mac_unit

// File: tb/tb_mac_unit.sv
// Directed self-checking bench for mac_unit, with a caller-side accumulator fed back as sum_in.
module tb_mac_unit;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    operand_a_t data_in_a;
    operand_b_t data_in_b;
    acc_t       sum_in;
    logic       o_valid;
    acc_t       sum_out;

    acc_t sum_drv;
    acc_t acc;
    logic use_acc;
    logic acc_clr;
    int   vcount = 0;
    int   base;

    int vectors     = 0;
    int miscompares = 0;

    mac_unit dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .data_in_a (data_in_a),
        .data_in_b (data_in_b),
        .sum_in    (sum_in),
        .o_valid   (o_valid),
        .sum_out   (sum_out)
    );

    always #5 clk = ~clk;

    assign sum_in = use_acc ? acc : sum_drv;

    always @(posedge clk) begin
        if (acc_clr) acc <= '0;
        else if (use_acc && o_valid) acc <= sum_out;
        if (o_valid) vcount <= vcount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; data_in_a = '0; data_in_b = '0;
        sum_drv = '0; use_acc = 1'b0; acc_clr = 1'b1;
        step(); step();
        rst = 1'b0; acc_clr = 1'b0; sum_drv = 123;
        #1;
        check("reset_o_valid", o_valid, 0);
        check("reset_sum_passthru", sum_out, 123);

        // Single op: 10 + 3 * -4 = -2, two cycles after issue.
        step(); data_in_a = 3; data_in_b = -4; i_valid = 1'b1; sum_drv = 10; #1;
        check("single_n0_valid", o_valid, 0);
        step(); i_valid = 1'b0; #1;
        check("single_n1_valid", o_valid, 0);
        check("single_n1_sum", sum_out, 10);
        step(); #1;
        check("single_n2_valid", o_valid, 1);
        check("single_n2_sum", sum_out, -2);
        step(); #1;
        check("single_n3_valid", o_valid, 0);
        check("single_n3_sum", sum_out, 10);

        // Back-to-back accumulation: 2+4+6+8+10 = 30.
        step(); acc_clr = 1'b1; use_acc = 1'b1;
        step(); acc_clr = 1'b0; base = vcount;
        for (int k = 1; k <= 5; k++) begin
            data_in_a = k; data_in_b = 2; i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        repeat (6) step();
        check("b2b_pulses", vcount - base, 5);
        check("b2b_acc", acc, 30);

        // Extremes, issued back to back, then the wrap case.
        use_acc = 1'b0; sum_drv = 0;
        data_in_a = -(2**21); data_in_b = -(2**21); i_valid = 1'b1;
        step(); data_in_b = (2**21) - 1;
        step(); data_in_a = 1; data_in_b = 1; #1;
        check("ext_negneg_valid", o_valid, 1);
        check("ext_negneg_sum", sum_out, 64'sd1 <<< 42);
        step(); i_valid = 1'b0; #1;
        check("ext_negpos_sum", sum_out, -(64'sd1 <<< 42) + (64'sd1 <<< 21));
        step(); sum_drv = 48'h7FFF_FFFF_FFFF; #1;
        check("wrap_valid", o_valid, 1);
        check("wrap_sum", sum_out, -(64'sd1 <<< 47));

        // Bubbles and reset: pattern 1,0,1 then reset one cycle after the last valid.
        step(); sum_drv = 5;
        data_in_a = 2; data_in_b = 3; i_valid = 1'b1;
        step(); i_valid = 1'b0;
        step(); data_in_a = 7; data_in_b = 7; i_valid = 1'b1; #1;
        check("bubble_first_valid", o_valid, 1);
        check("bubble_first_sum", sum_out, 11);
        step(); rst = 1'b1; i_valid = 1'b0; #1;
        check("bubble_gap_valid", o_valid, 0);
        step(); rst = 1'b0; #1;
        check("reset_drop_valid", o_valid, 0);
        check("reset_drop_sum", sum_out, 5);
        step(); #1;
        check("post_reset_valid_1", o_valid, 0);
        step(); #1;
        check("post_reset_valid_2", o_valid, 0);

        // FC-length stream: sum of 0..224 = 25200.
        acc_clr = 1'b1; use_acc = 1'b1;
        step(); acc_clr = 1'b0; base = vcount;
        for (int k = 0; k < 225; k++) begin
            data_in_a = k; data_in_b = 1; i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        repeat (6) step();
        check("fc_pulses", vcount - base, 225);
        check("fc_acc", acc, 25200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mac_unit
